line_shift_ram_taps: RTL and testbench
======================================

Name: line_shift_ram_taps

Overview:
Multi-tap line delay buffer for streaming pixel pipelines. It generalises the single-line shift RAM to TAP_NUM cascaded line delays with a runtime-selectable line length, and it advances only on accepted samples. Outputs all delayed lines in parallel so downstream window generators (3x3, 5x5 filters) can read a vertical column per cycle. Sits between the pixel source and the window/convolution stages.

Parameters:
LINE_LENGTH, 640, maximum samples per line; sets the depth of each line RAM.
INPUT_WIDTH, 8, sample width in bits.
TAP_NUM, 2, number of cascaded line delays (1..8).

Ports:
clock  input  1  system clock, rising edge.
clr  input  1  asynchronous active-high reset.
clken  input  1  sample valid; buffer advances only when high.
shiftin  input  INPUT_WIDTH  incoming sample.
line_len  input  16  active line length; applied at line boundaries.
taps  output  TAP_NUM*INPUT_WIDTH  delayed samples; slice k = [(k+1)*INPUT_WIDTH-1 : k*INPUT_WIDTH] is delayed by (k+1) lines.
taps_valid  output  1  one-cycle pulse marking taps updated.
primed  output  1  high once all TAP_NUM lines are filled.

Behaviour:
- Reset (clr high, async): taps=0, taps_valid=0, primed=0, write pointer=0, fill count=0, active length reloaded from line_len on first clken after release. RAM contents are not cleared.
- Effective length L: line_len when 1 <= line_len <= LINE_LENGTH; otherwise LINE_LENGTH. Latched when pointer is 0 and clken high (start of each line); mid-line changes are ignored until the next wrap.
- One shared pointer, range 0..L-1. On clken: read entry [ptr] of every line RAM (read-before-write), write shiftin to RAM0[ptr], write RAM(k-1)[ptr] read data into RAMk[ptr], then ptr advances; ptr wraps to 0 after L-1.
- clken low: pointer, RAMs, taps hold; taps_valid=0. There is no zero-stuffing of idle cycles.
- Latency: taps register updates the cycle after the accepting clken edge; taps_valid is high in that same cycle. Tap k equals the sample accepted (k+1)*L accepted samples earlier.
- Fill count increments at each pointer wrap and saturates at TAP_NUM. Tap k outputs 0 until fill count > k, so uninitialised RAM never appears. primed = (fill count == TAP_NUM), registered. It rises with the taps_valid of the first sample of line TAP_NUM+1.
- Back-to-back clken every cycle sustains 1 sample/cycle with no bubbles.
- clr asserted mid-line: all state returns to reset values immediately. Stale RAM data is masked by the fill count.
- Width rules: line_len is 16 bits; LINE_LENGTH must be <= 65535. Pointer width is clog2(LINE_LENGTH).

Optional Feature:
LINE_SHIFT_SOF_EN. When defined, this adds input sof (1 bit). When sof and clken are high together, the current sample is written at ptr=0, the fill count clears to 0, line_len is re-latched, and primed drops on the next cycle. This is a synchronous frame restart without clr. When the macro is undefined, the sof port is absent and only clr restarts the buffer.

Test Plan:
1. LINE_LENGTH=4, TAP_NUM=2, line_len=4; clken continuous; shiftin=1,2,3,... -> tap0 is 0 through sample 4. The cycle after sample 5, tap0=1 and tap1=0. After sample 9, tap0=5, tap1=1, and primed rises.
2. Same setup, clken toggling 1-0-1-0 -> taps_valid pulses only after accepted samples. Values match test 1 in sample order, and taps hold during gaps.
3. LINE_LENGTH=8, line_len=3, then line_len=5 written mid-line -> delay stays 3 until the pointer wraps, then becomes 5. line_len=0 or 9 -> delay 8.
4. Assert clr for 1 cycle after 6 samples (LINE_LENGTH=4) -> taps=0, primed=0, taps_valid=0 immediately. Refill gives tap0 nonzero only after 4 new samples, with no stale data visible.
5. TAP_NUM=3, line_len=4, 20 samples -> tap2 equals the sample from 12 earlier. primed asserts with the taps_valid of sample 13.
6. With LINE_SHIFT_SOF_EN: 10 samples, then sof with sample 100 -> primed low the next cycle, fill count 0, and tap0 shows 100 after 4 more samples.

Source files
------------

// File: rtl/line_shift_ram_taps.sv
// Multi-tap line delay: TAP_NUM cascaded line RAMs sharing one pointer, advancing on clken only.
// Optional define LINE_SHIFT_SOF_EN adds a sof input for a synchronous frame restart.
module line_shift_ram_taps #(
  parameter int LINE_LENGTH = 640,
  parameter int INPUT_WIDTH = 8,
  parameter int TAP_NUM     = 2
) (
  input  logic                           clock,
  input  logic                           clr,
  input  logic                           clken,
`ifdef LINE_SHIFT_SOF_EN
  input  logic                           sof,
`endif
  input  logic [INPUT_WIDTH-1:0]         shiftin,
  input  logic [15:0]                    line_len,
  output logic [TAP_NUM*INPUT_WIDTH-1:0] taps,
  output logic                           taps_valid,
  output logic                           primed
);

  localparam int PW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int FW = $clog2(TAP_NUM + 1);
  localparam logic [16:0] MAX_LEN = 17'(LINE_LENGTH);

  logic              sof_w;
  logic [PW-1:0]     ptr_q, ptr_d, addr, wr_addr_q;
  logic [16:0]       len_q, len_d, len_sel, cur_len;
  logic [FW-1:0]     fill_q, fill_d, fill_live;
  logic [TAP_NUM-1:0] mask_q, mask_d;
  logic              start, wrap;
  logic              taps_valid_q, primed_q, pend_q, fwd_q;
  logic [INPUT_WIDTH-1:0] rd_all [TAP_NUM];

`ifdef LINE_SHIFT_SOF_EN
  assign sof_w = sof;
`else
  assign sof_w = 1'b0;
`endif

  always_comb begin
    len_sel = MAX_LEN;
    if (line_len != 16'd0 && {1'b0, line_len} <= MAX_LEN) begin
      len_sel = {1'b0, line_len};
    end
    start     = (ptr_q == '0) || sof_w;
    cur_len   = start ? len_sel : len_q;
    addr      = sof_w ? '0 : ptr_q;
    wrap      = ({{(17-PW){1'b0}}, addr} == cur_len - 17'd1);
    fill_live = sof_w ? '0 : fill_q;
    ptr_d  = ptr_q;
    len_d  = len_q;
    fill_d = fill_q;
    if (clken) begin
      len_d  = cur_len;
      ptr_d  = wrap ? '0 : addr + PW'(1);
      fill_d = (wrap && fill_live != FW'(TAP_NUM)) ? fill_live + FW'(1) : fill_live;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      ptr_q        <= '0;
      len_q        <= MAX_LEN;
      fill_q       <= '0;
      mask_q       <= '0;
      taps_valid_q <= 1'b0;
      primed_q     <= 1'b0;
      pend_q       <= 1'b0;
      fwd_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      fill_q       <= fill_d;
      taps_valid_q <= clken;
      // The cascade write into RAM k>=1 lands one edge after the accept.
      pend_q       <= clken;
      if (clken) begin
        mask_q   <= mask_d;
        primed_q <= (fill_live == FW'(TAP_NUM));
        fwd_q    <= pend_q && (wr_addr_q == addr);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clken) wr_addr_q <= addr;
  end

  for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_tap
    logic [INPUT_WIDTH-1:0] mem [LINE_LENGTH];
    logic [INPUT_WIDTH-1:0] rd_q;

    assign mask_d[gi] = (fill_live > FW'(gi));

    if (gi == 0) begin : g_head
      always_ff @(posedge clock) begin
        if (clken) begin
          mem[addr] <= shiftin;
          rd_q      <= mem[addr];
        end
      end
      assign rd_all[gi] = rd_q;
    end else begin : g_cascade
      logic [INPUT_WIDTH-1:0] fwd_data_q;
      always_ff @(posedge clock) begin
        if (pend_q) mem[wr_addr_q] <= rd_all[gi-1];
        if (clken) begin
          rd_q       <= mem[addr];
          fwd_data_q <= rd_all[gi-1];
        end
      end
      // Bypass the RAM when the read hits the entry still being written.
      assign rd_all[gi] = fwd_q ? fwd_data_q : rd_q;
    end

    assign taps[gi*INPUT_WIDTH +: INPUT_WIDTH] = mask_q[gi] ? rd_all[gi] : '0;
  end

  assign taps_valid = taps_valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_line_shift_ram_taps.sv
// Bench for line_shift_ram_taps (LINE_LENGTH=8, TAP_NUM=3): constant vector table plus scoreboard
// against a line-RAM reference model. Exercises sof when LINE_SHIFT_SOF_EN is defined.
module tb_line_shift_ram_taps;
  localparam int LL = 8;
  localparam int W  = 8;
  localparam int TN = 3;

  logic            clock = 1'b0;
  logic            clr, clken;
  logic [W-1:0]    shiftin;
  logic [15:0]     line_len;
  logic [TN*W-1:0] taps;
  logic            taps_valid, primed;
`ifdef LINE_SHIFT_SOF_EN
  logic            sof;
`endif

  always #5 clock = ~clock;

  line_shift_ram_taps #(.LINE_LENGTH(LL), .INPUT_WIDTH(W), .TAP_NUM(TN)) dut (
    .clock      (clock),
    .clr        (clr),
    .clken      (clken),
`ifdef LINE_SHIFT_SOF_EN
    .sof        (sof),
`endif
    .shiftin    (shiftin),
    .line_len   (line_len),
    .taps       (taps),
    .taps_valid (taps_valid),
    .primed     (primed)
  );

  typedef struct {
    logic [TN*W-1:0] taps;
    logic            primed;
  } exp_t;

  typedef struct {
    bit       en;
    logic [7:0] din;
    logic [7:0] t0, t1, t2;
    bit       p;
  } vec_t;

  int checks = 0;
  int failures = 0;
  exp_t sbq[$];
  logic [W-1:0] mmem [TN][LL];
  int mptr, mlen, mfill;
  exp_t hold;
  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int eff_len(input int v);
    return (v >= 1 && v <= LL) ? v : LL;
  endfunction

  // Reference: read every line RAM at ptr, then write the cascade, then advance.
  task automatic model_accept(input logic [W-1:0] d, input bit s);
    exp_t e;
    logic [W-1:0] rd [TN];
    int a, f;
    if (mptr == 0 || s) mlen = eff_len(int'(line_len));
    a = s ? 0 : mptr;
    f = s ? 0 : mfill;
    for (int k = 0; k < TN; k++) rd[k] = mmem[k][a];
    for (int k = 0; k < TN; k++) e.taps[k*W +: W] = (f > k) ? rd[k] : '0;
    e.primed = (f == TN);
    mmem[0][a] = d;
    for (int k = 1; k < TN; k++) mmem[k][a] = rd[k-1];
    if (a == mlen - 1) begin
      mptr = 0;
      if (f < TN) f++;
    end else begin
      mptr = a + 1;
    end
    mfill = f;
    sbq.push_back(e);
  endtask

  task automatic model_reset();
    mptr = 0;
    mfill = 0;
    hold.taps = '0;
    hold.primed = 1'b0;
    sbq.delete();
  endtask

  task automatic step(input bit en, input logic [W-1:0] d, input bit s);
    exp_t e;
    clken = en;
    shiftin = d;
`ifdef LINE_SHIFT_SOF_EN
    sof = s;
`endif
    if (en) model_accept(d, s);
    @(posedge clock);
    #1;
    check("taps_valid", {31'd0, taps_valid}, {31'd0, en});
    if (en) begin
      if (sbq.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("taps", {8'd0, taps}, {8'd0, e.taps});
        check("primed", {31'd0, primed}, {31'd0, e.primed});
        hold = e;
      end
    end else begin
      check("taps_hold", {8'd0, taps}, {8'd0, hold.taps});
      check("primed_hold", {31'd0, primed}, {31'd0, hold.primed});
    end
    clken = 1'b0;
`ifdef LINE_SHIFT_SOF_EN
    sof = 1'b0;
`endif
  endtask

  task automatic pulse_clr();
    clken = 1'b0;
    clr = 1'b1;
    #1;
    check("clr_taps", {8'd0, taps}, 32'd0);
    check("clr_valid", {31'd0, taps_valid}, 32'd0);
    check("clr_primed", {31'd0, primed}, 32'd0);
    @(posedge clock);
    #1;
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    // Line length 4 from reset, then 1-0-1-0 gaps; TAP_NUM=3 so primed arrives with sample 13.
    tbl[0]  = '{1, 8'd1,  8'd0,  8'd0, 8'd0, 0};
    tbl[1]  = '{1, 8'd2,  8'd0,  8'd0, 8'd0, 0};
    tbl[2]  = '{1, 8'd3,  8'd0,  8'd0, 8'd0, 0};
    tbl[3]  = '{1, 8'd4,  8'd0,  8'd0, 8'd0, 0};
    tbl[4]  = '{1, 8'd5,  8'd1,  8'd0, 8'd0, 0};
    tbl[5]  = '{1, 8'd6,  8'd2,  8'd0, 8'd0, 0};
    tbl[6]  = '{1, 8'd7,  8'd3,  8'd0, 8'd0, 0};
    tbl[7]  = '{1, 8'd8,  8'd4,  8'd0, 8'd0, 0};
    tbl[8]  = '{1, 8'd9,  8'd5,  8'd1, 8'd0, 0};
    tbl[9]  = '{1, 8'd10, 8'd6,  8'd2, 8'd0, 0};
    tbl[10] = '{1, 8'd11, 8'd7,  8'd3, 8'd0, 0};
    tbl[11] = '{1, 8'd12, 8'd8,  8'd4, 8'd0, 0};
    tbl[12] = '{1, 8'd13, 8'd9,  8'd5, 8'd1, 1};
    tbl[13] = '{1, 8'd14, 8'd10, 8'd6, 8'd2, 1};
    tbl[14] = '{0, 8'hEE, 8'd10, 8'd6, 8'd2, 1};
    tbl[15] = '{1, 8'd15, 8'd11, 8'd7, 8'd3, 1};
    tbl[16] = '{0, 8'hEE, 8'd11, 8'd7, 8'd3, 1};
    tbl[17] = '{1, 8'd16, 8'd12, 8'd8, 8'd4, 1};
    tbl[18] = '{0, 8'hEE, 8'd12, 8'd8, 8'd4, 1};
    tbl[19] = '{1, 8'd17, 8'd13, 8'd9, 8'd5, 1};

    for (int k = 0; k < TN; k++)
      for (int a = 0; a < LL; a++) mmem[k][a] = '0;

    clr = 1'b1;
    clken = 1'b0;
    shiftin = '0;
    line_len = 16'd0;
`ifdef LINE_SHIFT_SOF_EN
    sof = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_taps", {8'd0, taps}, 32'd0);
    check("reset_valid", {31'd0, taps_valid}, 32'd0);
    check("reset_primed", {31'd0, primed}, 32'd0);
    clr = 1'b0;
    step(0, 8'h55, 0);

    // line_len=0 selects the full 8; fills every RAM entry.
    for (int i = 0; i < 30; i++) step(1, W'($urandom), 0);
    line_len = 16'd9;
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), W'($urandom), 0);

    pulse_clr();
    line_len = 16'd4;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].din, 0);
      check($sformatf("tbl%0d_tap0", i), {24'd0, taps[7:0]},   {24'd0, tbl[i].t0});
      check($sformatf("tbl%0d_tap1", i), {24'd0, taps[15:8]},  {24'd0, tbl[i].t1});
      check($sformatf("tbl%0d_tap2", i), {24'd0, taps[23:16]}, {24'd0, tbl[i].t2});
      check($sformatf("tbl%0d_primed", i), {31'd0, primed}, {31'd0, tbl[i].p});
    end

    // Mid-line length change only takes effect at the next wrap.
    line_len = 16'd3;
    for (int i = 0; i < 13; i++) step(1, W'($urandom), 0);
    line_len = 16'd5;
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), W'($urandom), 0);
    line_len = 16'd0;
    for (int i = 0; i < 30; i++) step(1, W'($urandom), 0);
    line_len = 16'd1;
    for (int i = 0; i < 12; i++) step(1, W'($urandom), 0);
    line_len = 16'd2;
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), W'($urandom), 0);

    // Asynchronous clear after 6 samples; stale RAM must stay masked.
    pulse_clr();
    line_len = 16'd4;
    for (int i = 0; i < 6; i++) step(1, W'(i + 40), 0);
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      step(1, W'(i + 60), 0);
      check("refill_tap0_zero", {24'd0, taps[7:0]}, 32'd0);
    end
    step(1, 8'd64, 0);
    check("refill_tap0", {24'd0, taps[7:0]}, 32'd60);

`ifdef LINE_SHIFT_SOF_EN
    pulse_clr();
    for (int i = 0; i < 14; i++) step(1, W'(i + 1), 0);
    check("pre_sof_primed", {31'd0, primed}, 32'd1);
    step(1, 8'd100, 1);
    check("sof_primed", {31'd0, primed}, 32'd0);
    for (int i = 0; i < 3; i++) step(1, W'(i + 101), 0);
    step(1, 8'd104, 0);
    check("sof_tap0", {24'd0, taps[7:0]}, 32'd100);
    for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), W'($urandom), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
